// File: rtl/port_fifo_responder_pkg.sv
// ---------------------------------------------------------------------------
// port_fifo_pkg
// Shared types, default sizing and helpers for the port FIFO responder.
//   port_byte_t   : one byte as seen on the CPU I/O port pins
//   DEF_*         : default data width and FIFO depths
//   fall_edge()   : strobe falling-edge detect from registered and live level
// ---------------------------------------------------------------------------
package port_fifo_pkg;

  typedef logic [7:0] port_byte_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_IN_DEPTH  = 16;
  localparam int DEF_OUT_DEPTH = 16;

  // A strobe event is the cycle where last cycle's level was high and the
  // live level is low, so the event can be acted on in the same cycle.
  function automatic logic fall_edge(input logic prev, input logic cur);
    return prev & ~cur;
  endfunction

endpackage

// File: rtl/port_fifo_responder_if.sv
// ---------------------------------------------------------------------------
// port_fifo_responder_if
// Bundles the CPU port pins, the host push/pop handshakes and the sticky
// error flags of the port FIFO responder.
//   slave  : the responder side (drives in_port_0, host_wr_ready, host_rd_*,
//            flags)
//   master : the CPU pins plus host/harness side
// Optional (PORT_FIFO_STATUS_EN): in_count, out_count, clear_flags.
// ---------------------------------------------------------------------------
interface port_fifo_responder_if #(
  parameter int DATA_W    = 8,
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16
);

  logic [DATA_W-1:0] in_port_0;
  logic              in_strobe_0;
  logic [DATA_W-1:0] out_port_0;
  logic              out_strobe_0;
  logic [DATA_W-1:0] host_wr_data;
  logic              host_wr_valid;
  logic              host_wr_ready;
  logic [DATA_W-1:0] host_rd_data;
  logic              host_rd_valid;
  logic              host_rd_ready;
  logic              in_underflow;
  logic              out_overflow;
`ifdef PORT_FIFO_STATUS_EN
  logic [$clog2(IN_DEPTH):0]  in_count;
  logic [$clog2(OUT_DEPTH):0] out_count;
  logic                       clear_flags;
`endif

  modport slave (
    output in_port_0,
    input  in_strobe_0,
    input  out_port_0,
    input  out_strobe_0,
    input  host_wr_data,
    input  host_wr_valid,
    output host_wr_ready,
    output host_rd_data,
    output host_rd_valid,
    input  host_rd_ready,
    output in_underflow,
`ifdef PORT_FIFO_STATUS_EN
    output in_count,
    output out_count,
    input  clear_flags,
`endif
    output out_overflow
  );

  modport master (
    input  in_port_0,
    output in_strobe_0,
    output out_port_0,
    output out_strobe_0,
    output host_wr_data,
    output host_wr_valid,
    input  host_wr_ready,
    input  host_rd_data,
    input  host_rd_valid,
    output host_rd_ready,
    input  in_underflow,
`ifdef PORT_FIFO_STATUS_EN
    input  in_count,
    input  out_count,
    output clear_flags,
`endif
    input  out_overflow
  );

endinterface

// File: rtl/port_fifo_responder_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock circular FIFO with synchronous active-low reset.
//   clk, reset : clock, reset (0 = reset, empties the FIFO)
//   push_i     : enqueue data_i (ignored when full)
//   pop_i      : dequeue head (ignored when empty)
//   head_o     : oldest entry (undefined contents when empty; callers mask)
//   full_o, empty_o, count_o : occupancy status
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [DATA_W-1:0]        head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              doPush;
  logic              doPop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  // Requests are qualified here so a full push or an empty pop never moves a
  // pointer; pointers wrap naturally because DEPTH is a power of two.
  assign doPush = push_i & ~full_o;
  assign doPop  = pop_i & ~empty_o;

  // Next-state pointers and occupancy; a simultaneous push and pop leave the
  // count unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset only needs to clear these, the storage
  // contents are never visible while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/port_fifo_responder.sv
// ---------------------------------------------------------------------------
// port_fifo_responder
// Peripheral-side responder for the CPU I/O port 0 strobe protocol.
// Host bytes are queued in an input FIFO and presented on in_port_0; each
// falling edge of in_strobe_0 consumes one. Each falling edge of
// out_strobe_0 captures out_port_0 into an output FIFO drained by the host.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : port_fifo_responder_if.slave (CPU pins, host handshakes, flags)
// Build option PORT_FIFO_STATUS_EN adds in_count/out_count occupancy outputs
// and a clear_flags input on the interface.
// ---------------------------------------------------------------------------
module port_fifo_responder
  import port_fifo_pkg::*;
#(
  parameter int              DATA_W      = DEF_DATA_W,
  parameter int              IN_DEPTH    = DEF_IN_DEPTH,
  parameter int              OUT_DEPTH   = DEF_OUT_DEPTH,
  parameter logic [DATA_W-1:0] EMPTY_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  port_fifo_responder_if.slave  bus
);

  logic inStrobe_q, outStrobe_q;
  logic underflow_q, underflow_d;
  logic overflow_q, overflow_d;
  logic inFall, outFall;
  logic underflowSet, overflowSet;

  logic [DATA_W-1:0]         inHead, outHead;
  logic                      inFull, inEmpty, outFull, outEmpty;
  logic [$clog2(IN_DEPTH):0]  inCount;
  logic [$clog2(OUT_DEPTH):0] outCount;

  assign inFall  = fall_edge(inStrobe_q, bus.in_strobe_0);
  assign outFall = fall_edge(outStrobe_q, bus.out_strobe_0);

  assign underflowSet = inFall & inEmpty;
  assign overflowSet  = outFall & outFull;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(IN_DEPTH)) inFifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.host_wr_valid),
    .pop_i   (inFall),
    .data_i  (bus.host_wr_data),
    .head_o  (inHead),
    .full_o  (inFull),
    .empty_o (inEmpty),
    .count_o (inCount)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(OUT_DEPTH)) outFifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (outFall),
    .pop_i   (bus.host_rd_ready),
    .data_i  (bus.out_port_0),
    .head_o  (outHead),
    .full_o  (outFull),
    .empty_o (outEmpty),
    .count_o (outCount)
  );

  assign bus.in_port_0     = inEmpty ? EMPTY_VALUE : inHead;
  assign bus.host_wr_ready = ~inFull;
  assign bus.host_rd_valid = ~outEmpty;
  assign bus.host_rd_data  = outEmpty ? '0 : outHead;
  assign bus.in_underflow  = underflow_q;
  assign bus.out_overflow  = overflow_q;

`ifdef PORT_FIFO_STATUS_EN
  assign bus.in_count  = inCount;
  assign bus.out_count = outCount;
`else
  // Occupancies only leave the block in the status build.
  logic unusedCounts;
  assign unusedCounts = ^{inCount, outCount};
`endif

  // Sticky error flags; a clear request loses to an error in the same cycle
  // so no event is ever silently lost.
  always_comb begin
    underflow_d = underflow_q | underflowSet;
    overflow_d  = overflow_q | overflowSet;
`ifdef PORT_FIFO_STATUS_EN
    if (bus.clear_flags) begin
      underflow_d = underflowSet;
      overflow_d  = overflowSet;
    end
`endif
  end

  // Strobe history and flags. History clears to 0 so a strobe that is
  // already high when reset lifts must be seen high before it can fall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inStrobe_q  <= 1'b0;
      outStrobe_q <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      inStrobe_q  <= bus.in_strobe_0;
      outStrobe_q <= bus.out_strobe_0;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_port_fifo_responder.sv
// ---------------------------------------------------------------------------
// tb_port_fifo_responder
// Directed bench for port_fifo_responder with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_port_fifo_responder;
  import port_fifo_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vectorCount = 0;
  int   missCount   = 0;

  port_fifo_responder_if #(.DATA_W(8), .IN_DEPTH(16), .OUT_DEPTH(16)) bus ();

  port_fifo_responder #(
    .DATA_W(8), .IN_DEPTH(16), .OUT_DEPTH(16), .EMPTY_VALUE(8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive every input for one clock cycle, then settle just past the edge.
  task automatic applyStimulus(input logic rst, input logic wrValid,
                               input port_byte_t wrData, input logic inStrobe,
                               input logic outStrobe, input port_byte_t outPort,
                               input logic rdReady);
    reset             = rst;
    bus.host_wr_valid = wrValid;
    bus.host_wr_data  = wrData;
    bus.in_strobe_0   = inStrobe;
    bus.out_strobe_0  = outStrobe;
    bus.out_port_0    = outPort;
    bus.host_rd_ready = rdReady;
    @(posedge clk);
    #1;
  endtask

  port_byte_t exp1 [3] = '{8'd3, 8'd4, 8'd0};
  port_byte_t vals3[4] = '{8'd2, 8'd4, 8'd5, 8'd9};

  initial begin
    reset             = 1'b0;
    bus.host_wr_valid = 1'b0;
    bus.host_wr_data  = '0;
    bus.in_strobe_0   = 1'b0;
    bus.out_strobe_0  = 1'b0;
    bus.out_port_0    = '0;
    bus.host_rd_ready = 1'b0;
`ifdef PORT_FIFO_STATUS_EN
    bus.clear_flags   = 1'b0;
`endif

    // Reset state
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst in_port", bus.in_port_0, 0);
    checkOutput("rst wr_ready", bus.host_wr_ready, 1);
    checkOutput("rst rd_valid", bus.host_rd_valid, 0);
    checkOutput("rst rd_data", bus.host_rd_data, 0);
    checkOutput("rst underflow", bus.in_underflow, 0);
    checkOutput("rst overflow", bus.out_overflow, 0);

    // 1: host pushes 5,3,4; three input strobe falls walk the head
    applyStimulus(1, 1, 8'd5, 0, 0, 0, 0);
    applyStimulus(1, 1, 8'd3, 0, 0, 0, 0);
    applyStimulus(1, 1, 8'd4, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    checkOutput("t1 head0", bus.in_port_0, 8'd5);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("t1 head%0d", i + 1), bus.in_port_0, exp1[i]);
      if (i < 2) applyStimulus(1, 0, 0, 1, 0, 0, 0);
    end
    checkOutput("t1 underflow", bus.in_underflow, 0);

    // 2: strobe fall on an empty input FIFO
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t2 underflow", bus.in_underflow, 1);
    checkOutput("t2 in_port", bus.in_port_0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2 underflow clr", bus.in_underflow, 0);

    // 3: CPU writes 2,4,5,9; data sampled in the falling cycle
    foreach (vals3[i]) begin
      applyStimulus(1, 0, 0, 0, 1, 8'h77, 0);
      applyStimulus(1, 0, 0, 0, 0, vals3[i], 0);
    end
    checkOutput("t3 rd_valid", bus.host_rd_valid, 1);
    foreach (vals3[i]) begin
      checkOutput($sformatf("t3 pop%0d", i), bus.host_rd_data, vals3[i]);
      applyStimulus(1, 0, 0, 0, 0, 0, 1);
    end
    checkOutput("t3 drained valid", bus.host_rd_valid, 0);
    checkOutput("t3 drained data", bus.host_rd_data, 0);

    // 4: fill output FIFO, one extra write is dropped
    checkOutput("t4 overflow pre", bus.out_overflow, 0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 0, 0, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, (i == 16) ? 8'hEE : 8'(8'h10 + i), 0);
    end
    checkOutput("t4 overflow", bus.out_overflow, 1);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("t4 pop%0d", i), bus.host_rd_data, 8'(8'h10 + i));
      applyStimulus(1, 0, 0, 0, 0, 0, 1);
    end
    checkOutput("t4 drained valid", bus.host_rd_valid, 0);
    checkOutput("t4 overflow sticky", bus.out_overflow, 1);

    // 5: same-cycle push and pop with one entry held
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 8'd7, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 8'd8, 0, 0, 0, 0);
    checkOutput("t5 new head", bus.in_port_0, 8'd8);
    checkOutput("t5 wr_ready", bus.host_wr_ready, 1);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t5 count one", bus.in_port_0, 0);
    checkOutput("t5 underflow", bus.in_underflow, 0);

    // 6: reset while half full with out_strobe held high
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 8'(8'h20 + i), 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 0, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 8'(8'h40 + i), 0);
    end
    applyStimulus(1, 0, 0, 0, 1, 8'h55, 0);
    checkOutput("t6 pre in_port", bus.in_port_0, 8'h20);
    checkOutput("t6 pre rd_data", bus.host_rd_data, 8'h40);
    applyStimulus(0, 0, 0, 0, 1, 8'h55, 0);
    checkOutput("t6 in_port", bus.in_port_0, 0);
    checkOutput("t6 wr_ready", bus.host_wr_ready, 1);
    checkOutput("t6 rd_valid", bus.host_rd_valid, 0);
    checkOutput("t6 rd_data", bus.host_rd_data, 0);
    applyStimulus(1, 0, 0, 0, 0, 8'h66, 0);
    checkOutput("t6 no capture", bus.host_rd_valid, 0);
    applyStimulus(1, 0, 0, 0, 1, 8'h66, 0);
    applyStimulus(1, 0, 0, 0, 0, 8'h66, 0);
    checkOutput("t6 capture valid", bus.host_rd_valid, 1);
    checkOutput("t6 capture data", bus.host_rd_data, 8'h66);

    // 7: full input FIFO keeps wr_ready low through a same-cycle pop
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 8'(8'h30 + i), 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t7 full ready", bus.host_wr_ready, 0);
    applyStimulus(1, 1, 8'hAB, 1, 0, 0, 0);
    applyStimulus(1, 1, 8'hAB, 0, 0, 0, 0);
    checkOutput("t7 head after pop", bus.in_port_0, 8'h31);
    checkOutput("t7 ready after pop", bus.host_wr_ready, 1);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1, 0, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
    end
    checkOutput("t7 drained", bus.in_port_0, 0);
    checkOutput("t7 underflow", bus.in_underflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
